// File: rtl/serial_byte_rx_pkg.sv
// Shared definitions for the serial byte receiver: default geometry and FSM state encoding.
package serial_byte_rx_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int CLKS_PER_BIT_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

endpackage

// File: rtl/serial_byte_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; resets to 1 so an idle-high line
// never looks like a start bit while coming out of reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] chain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_reg <= 2'b11;
    else        chain_reg <= {chain_reg[0], d};
  end

  assign q = chain_reg[1];

endmodule

// File: rtl/serial_byte_rx.sv
// Serial-to-parallel receiver: start/data/stop framing, LSB first, mid-bit sampling,
// held byte output with one-cycle valid / framing-error pulses.
module serial_byte_rx
  import serial_byte_rx_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  input  logic              enable,
  output logic [DATA_W-1:0] a_out,
  output logic              byte_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int H     = CLKS_PER_BIT / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic              rx_s;
  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] a_out_reg;
  logic              byte_valid_reg;
  logic              frame_err_reg;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shift_reg      <= '0;
      a_out_reg      <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!rx_s && enable) begin
            state_reg <= ST_START;
            cnt_reg   <= '0;
          end
        end
        // Re-check the line half a bit in so a short low glitch is not taken as a start.
        ST_START: begin
          if (cnt_reg == CNT_HALF) begin
            cnt_reg <= '0;
            if (!rx_s) begin
              state_reg <= ST_DATA;
              idx_reg   <= '0;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_reg == CNT_LAST) begin
            shift_reg <= DATA_W'({rx_s, shift_reg} >> 1);
            cnt_reg   <= '0;
            idx_reg   <= idx_reg + 1'b1;
            if (idx_reg == IDX_LAST) state_reg <= ST_STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            if (rx_s) begin
              a_out_reg      <= shift_reg;
              byte_valid_reg <= 1'b1;
              state_reg      <= ST_IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= ST_WAIT_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        // After a bad stop bit, wait for the line to go idle so a stuck-low line cannot restart.
        ST_WAIT_IDLE: begin
          if (rx_s) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign a_out      = a_out_reg;
  assign byte_valid = byte_valid_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed and randomized frames against a frame-level expectation of when and what
// each receiver pulse should be.
module tb_serial_byte_rx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
  localparam int H      = CPB / 2;
  localparam int LAT    = 2 + H + (DATA_W + 1) * CPB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              rx_in = 1'b1;
  logic              enable = 1'b1;
  logic [DATA_W-1:0] a_out;
  logic              byte_valid;
  logic              frame_err;
  logic              busy;

  serial_byte_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .enable     (enable),
    .a_out      (a_out),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    bit              err;
    logic [DATA_W-1:0] val;
  } ev_t;

  int  cyc = 0;
  ev_t evq[$];
  int  busy_cnt = 0;
  int  overlap_cnt = 0;
  int  rd = 0;
  int  n_assert = 0;
  int  n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every pulse with the edge index that produced it and the bus value at that time.
  always @(negedge clk) begin
    if (byte_valid === 1'b1) evq.push_back('{cyc, 1'b0, a_out});
    if (frame_err === 1'b1)  evq.push_back('{cyc, 1'b1, a_out});
    if (byte_valid === 1'b1 && frame_err === 1'b1) overlap_cnt <= overlap_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input string tag, input int c, input bit err, input logic [DATA_W-1:0] v);
    chk({tag, "_present"}, 32'(evq.size() > rd), 32'd1);
    if (evq.size() > rd) begin
      chk({tag, "_cyc"},  evq[rd].cyc, c);
      chk({tag, "_kind"}, 32'(evq[rd].err), 32'(err));
      chk({tag, "_val"},  32'(evq[rd].val), 32'(v));
      rd++;
    end
  endtask

  task automatic chk_no_new(input string tag);
    chk(tag, evq.size() - rd, 0);
    rd = evq.size();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] b, input logic stop_bit, input int nbits,
                            output int p0);
    logic [DATA_W+1:0] fr;
    fr = {stop_bit, b, 1'b0};
    p0 = 0;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (i == 0 && c == 0) p0 = cyc + 1;
        rx_in = fr[i];
      end
    end
  endtask

  initial begin
    int p0, p1, b0, nlow, nhigh, r;
    logic [DATA_W-1:0] b, last;
    ev_t expq[$];

    // Reset and idle line
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_aout", 32'(a_out), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({byte_valid, frame_err}), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({a_out, byte_valid, frame_err, busy}), 32'd0);
    end

    // Single frame 0x04
    send_frame(8'h04, 1'b1, 10, p0);
    idle(4);
    expect_ev("f04", p0 + LAT, 1'b0, 8'h04);
    chk_no_new("f04_single_pulse");
    idle(10);
    chk("f04_hold", 32'(a_out), 32'h04);

    // One-cycle glitch
    b0 = busy_cnt;
    @(negedge clk); rx_in = 1'b0;
    @(negedge clk); rx_in = 1'b1;
    idle(8);
    chk("glitch_busy_le2", 32'((busy_cnt - b0) <= 2), 32'd1);
    chk_no_new("glitch_no_pulse");
    chk("glitch_aout", 32'(a_out), 32'h04);
    chk("glitch_idle", 32'(busy), 32'd0);

    // Framing error with stuck-low line
    send_frame(8'hA5, 1'b0, 10, p0);
    repeat (20) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    chk("ferr_wait_busy", 32'(busy), 32'd1);
    expect_ev("ferr", p0 + LAT, 1'b1, 8'h04);
    chk_no_new("ferr_single_pulse");
    chk("ferr_aout", 32'(a_out), 32'h04);
    idle(5);
    chk("ferr_release", 32'(busy), 32'd0);

    // Back-to-back frames
    send_frame(8'h3C, 1'b1, 10, p0);
    send_frame(8'hFF, 1'b1, 10, p1);
    idle(4);
    expect_ev("b2b_first", p0 + LAT, 1'b0, 8'h3C);
    expect_ev("b2b_second", p1 + LAT, 1'b0, 8'hFF);
    chk_no_new("b2b_count");

    // Reset during data bit 4
    send_frame(8'hC3, 1'b1, 5, p0);
    @(negedge clk); rx_in = 1'b0;
    @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_aout", 32'(a_out), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pulses", 32'({byte_valid, frame_err}), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Disabled frame is ignored, then accepted once enabled
    enable = 1'b0;
    b0 = busy_cnt;
    send_frame(8'h55, 1'b1, 10, p0);
    idle(6);
    chk("dis_busy", busy_cnt - b0, 0);
    chk_no_new("dis_no_pulse");
    chk("dis_aout", 32'(a_out), 32'h00);
    enable = 1'b1;
    idle(2);
    send_frame(8'h55, 1'b1, 10, p0);
    idle(4);
    expect_ev("en55", p0 + LAT, 1'b0, 8'h55);
    chk_no_new("en55_single");
    chk("en55_aout", 32'(a_out), 32'h55);

    // Random frames: good, bad stop bit, or disabled, with random gaps
    last = 8'h55;
    for (int n = 0; n < 40; n++) begin
      b = DATA_W'($urandom_range(0, 255));
      r = int'($urandom_range(0, 9));
      enable = (r >= 2);
      if (r < 2) begin
        send_frame(b, 1'b1, 10, p0);
      end else if (r < 4) begin
        send_frame(b, 1'b0, 10, p0);
        expq.push_back('{p0 + LAT, 1'b1, last});
        nlow  = int'($urandom_range(0, 10));
        nhigh = int'($urandom_range(1, 4));
        repeat (nlow) begin
          @(negedge clk);
          rx_in = 1'b0;
        end
        idle(nhigh);
      end else begin
        send_frame(b, 1'b1, 10, p0);
        expq.push_back('{p0 + LAT, 1'b0, b});
        last = b;
      end
      idle(int'($urandom_range(0, 3)));
    end
    enable = 1'b1;
    idle(8);
    chk("rand_count", evq.size() - rd, expq.size());
    foreach (expq[i]) expect_ev($sformatf("rand%0d", i), expq[i].cyc, expq[i].err, expq[i].val);
    chk("rand_final_aout", 32'(a_out), 32'(last));
    chk("no_overlap", overlap_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
